// File: rtl/fc_pkg.sv
// Shared sizes and FSM encoding for the fully-connected classifier stage.
package fc_pkg;
    localparam int FC_DATA_SIZE = 32;
    localparam int FC_MEM_SIZE  = 16;
    localparam int FC_FRAC      = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_MAC  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } fc_state_e;
endpackage

// File: rtl/fc_mac.sv
// Multiply-accumulate datapath: bias load, signed MAC, then shift, saturate and optional ReLU.
module fc_mac
    import fc_pkg::*;
#(
    parameter int DATA_SIZE = FC_DATA_SIZE,
    parameter int FRAC      = FC_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 acc_en,
    input  logic                 load,
    input  logic                 bias_only,
    input  logic                 relu,
    input  logic [DATA_SIZE-1:0] in_rd,
    input  logic [DATA_SIZE-1:0] w_rd,
    input  logic [DATA_SIZE-1:0] b_rd,
    output logic [DATA_SIZE-1:0] result
);
    localparam int PROD_W = 2 * DATA_SIZE;
    localparam int ACC_W  = PROD_W + 8;
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    logic signed [PROD_W-1:0] in_ext, w_ext, prod;
    logic signed [ACC_W-1:0]  acc, acc_d, bias_ext, prod_ext, res_src, shifted;
    logic [DATA_SIZE-1:0]     sat;

    assign in_ext   = {{DATA_SIZE{in_rd[DATA_SIZE-1]}}, in_rd};
    assign w_ext    = {{DATA_SIZE{w_rd[DATA_SIZE-1]}}, w_rd};
    assign prod     = in_ext * w_ext;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_SIZE){b_rd[DATA_SIZE-1]}}, b_rd};
    assign acc_d    = (load ? bias_ext : acc) + prod_ext;

    // With no inputs the bias read issued in ADDR is the whole result.
    assign res_src = bias_only ? bias_ext : acc;
    assign shifted = res_src >>> FRAC;

    always_comb begin
        sat = shifted[DATA_SIZE-1:0];
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[DATA_SIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[DATA_SIZE-1:0];
        end
        result = (relu && sat[DATA_SIZE-1]) ? '0 : sat;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_d;
        end
    end
endmodule

// File: rtl/fc_layer.sv
// Fully-connected layer sequencer: walks neurons and inputs, drives memory addresses,
// and writes one saturated result word per neuron.
//   state | meaning
//   IDLE  | waiting for en; samples N_IN/N_OUT/RELU on leaving
//   ADDR  | issues bias, first input and first weight reads for neuron o
//   MAC   | accumulates one input*weight per cycle, N_IN cycles
//   WR    | writes result for neuron o, advances o
//   DONE  | job complete, done held until en falls
module fc_layer
    import fc_pkg::*;
#(
    parameter int DATA_SIZE = FC_DATA_SIZE,
    parameter int MEM_SIZE  = FC_MEM_SIZE,
    parameter int FRAC      = FC_FRAC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_SIZE-1:0] N_IN,
    input  logic [DATA_SIZE-1:0] N_OUT,
    input  logic                 RELU,
    input  logic [DATA_SIZE-1:0] in_rd,
    input  logic [DATA_SIZE-1:0] w_rd,
    input  logic [DATA_SIZE-1:0] b_rd,
    output logic                 done,
    output logic [MEM_SIZE-1:0]  in_ra,
    output logic [MEM_SIZE-1:0]  w_ra,
    output logic [MEM_SIZE-1:0]  b_ra,
    output logic                 out_we,
    output logic [MEM_SIZE-1:0]  out_wa,
    output logic [DATA_SIZE-1:0] out_wd
);
    fc_state_e            state, state_nxt;
    logic [MEM_SIZE-1:0]  n_in_r, n_out_r, o_cnt, j_cnt, wptr;
    logic                 relu_r, last_j, more_out;
    logic [DATA_SIZE-1:0] result, out_wd_q;
    logic                 unused_hi;

    assign unused_hi = ^{N_IN[DATA_SIZE-1:MEM_SIZE], N_OUT[DATA_SIZE-1:MEM_SIZE]};

    assign last_j   = (j_cnt == (n_in_r - MEM_SIZE'(1)));
    assign more_out = (({1'b0, o_cnt} + (MEM_SIZE+1)'(1)) < {1'b0, n_out_r});

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (en) state_nxt = (N_OUT[MEM_SIZE-1:0] == '0) ? ST_DONE : ST_ADDR;
            ST_ADDR: begin
                if (!en)                 state_nxt = ST_IDLE;
                else if (n_in_r == '0)   state_nxt = ST_WR;
                else                     state_nxt = ST_MAC;
            end
            ST_MAC: begin
                if (!en)                 state_nxt = ST_IDLE;
                else if (last_j)         state_nxt = ST_WR;
            end
            ST_WR: begin
                if (!en)                 state_nxt = ST_IDLE;
                else if (more_out)       state_nxt = ST_ADDR;
                else                     state_nxt = ST_DONE;
            end
            ST_DONE: if (!en) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A write whose cycle coincides with en falling is dropped along with the job.
    assign done   = (state == ST_DONE);
    assign out_we = (state == ST_WR) && en;
    assign out_wa = o_cnt;
    assign out_wd = out_we ? result : out_wd_q;
    assign b_ra   = (state == ST_ADDR) ? o_cnt : '0;
    assign in_ra  = (state == ST_MAC) ? j_cnt + MEM_SIZE'(1) : '0;
    assign w_ra   = (state == ST_ADDR) ? wptr :
                    (state == ST_MAC)  ? wptr + MEM_SIZE'(1) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            n_in_r   <= '0;
            n_out_r  <= '0;
            relu_r   <= 1'b0;
            o_cnt    <= '0;
            j_cnt    <= '0;
            wptr     <= '0;
            out_wd_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (en) begin
                    n_in_r  <= N_IN[MEM_SIZE-1:0];
                    n_out_r <= N_OUT[MEM_SIZE-1:0];
                    relu_r  <= RELU;
                    o_cnt   <= '0;
                    j_cnt   <= '0;
                    wptr    <= '0;
                end
                // wptr runs continuously across neurons, so row o starts at o*N_IN for free.
                ST_MAC: if (en) begin
                    j_cnt <= last_j ? '0 : j_cnt + MEM_SIZE'(1);
                    wptr  <= wptr + MEM_SIZE'(1);
                end
                ST_WR: if (en) begin
                    o_cnt    <= o_cnt + MEM_SIZE'(1);
                    out_wd_q <= result;
                end
                default: ;
            endcase
        end
    end

    fc_mac #(
        .DATA_SIZE (DATA_SIZE),
        .FRAC      (FRAC)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .acc_en    ((state == ST_MAC) && en),
        .load      (j_cnt == '0),
        .bias_only (n_in_r == '0),
        .relu      (relu_r),
        .in_rd     (in_rd),
        .w_rd      (w_rd),
        .b_rd      (b_rd),
        .result    (result)
    );
endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: expected words queued at job start, popped on each out_we.
module tb_fc_layer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        RELU = 1'b0;
    logic [31:0] N_IN = '0;
    logic [31:0] N_OUT = '0;
    logic [31:0] in_rd, w_rd, b_rd;
    logic        done, out_we;
    logic [15:0] in_ra, w_ra, b_ra, out_wa;
    logic [31:0] out_wd;

    logic [31:0] in_mem  [256];
    logic [31:0] w_mem   [256];
    logic [31:0] b_mem   [256];
    logic [31:0] out_mem [256];

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int passed = 0;
    int total = 0;
    int n_writes = 0;

    always #5 clk = ~clk;

    fc_layer dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .RELU   (RELU),
        .in_rd  (in_rd),
        .w_rd   (w_rd),
        .b_rd   (b_rd),
        .done   (done),
        .in_ra  (in_ra),
        .w_ra   (w_ra),
        .b_ra   (b_ra),
        .out_we (out_we),
        .out_wa (out_wa),
        .out_wd (out_wd)
    );

    always @(posedge clk) begin
        in_rd <= in_mem[in_ra[7:0]];
        w_rd  <= w_mem[w_ra[7:0]];
        b_rd  <= b_mem[b_ra[7:0]];
    end

    always @(negedge clk) begin
        if (out_we) begin
            n_writes++;
            out_mem[out_wa[7:0]] = out_wd;
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_write unexpected write addr=%0d data=%h, required none", out_wa, out_wd);
            end else begin
                mon_e = sb.pop_front();
                if (out_wa !== mon_e.addr || out_wd !== mon_e.data)
                    $display("FAIL sb_write got addr=%0d data=%h, required addr=%0d data=%h",
                             out_wa, out_wd, mon_e.addr, mon_e.data);
                else
                    passed++;
            end
        end
    end

    function automatic logic [31:0] model(int ni, int o, bit relu);
        logic signed [71:0] acc, a, b, sh;
        logic [31:0] r;
        acc = {{40{b_mem[o][31]}}, b_mem[o]};
        for (int i = 0; i < ni; i++) begin
            a = {{40{in_mem[i][31]}}, in_mem[i]};
            b = {{40{w_mem[o*ni+i][31]}}, w_mem[o*ni+i]};
            acc = acc + a * b;
        end
        sh = acc >>> 8;
        if (sh > 72'sd2147483647)       r = 32'h7FFF_FFFF;
        else if (sh < -72'sd2147483648) r = 32'h8000_0000;
        else                            r = sh[31:0];
        if (relu && r[31]) r = '0;
        return r;
    endfunction

    task automatic push_job(input int ni, input int no, input bit relu);
        for (int o = 0; o < no; o++) sb.push_back('{addr: 16'(o), data: model(ni, o, relu)});
    endtask

    // Called at posedge+1; the next edge is the start edge k. Config is scrambled
    // after k so that any late resampling would show up in the results.
    task automatic run_and_wait(input int ni, input int no, input bit relu,
                                input int exp_edges, input string name);
        int edges;
        N_IN = ni; N_OUT = no; RELU = relu; en = 1'b1;
        @(posedge clk); #1;
        N_IN = ni + 1; N_OUT = no + 1; RELU = ~relu;
        edges = 0;
        while (!done && edges < 3000) begin
            @(posedge clk); #1;
            edges++;
        end
        total++;
        if (edges !== exp_edges) $display("FAIL %s_latency got %0d edges, required %0d", name, edges, exp_edges);
        else passed++;
        total++;
        if (sb.size() !== 0) $display("FAIL %s_drain got %0d pending, required 0", name, sb.size());
        else passed++;
    endtask

    task automatic end_job(input string name);
        en = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) $display("FAIL %s_done_drop got %b, required 0", name, done);
        else passed++;
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) begin in_mem[i] = '0; w_mem[i] = '0; b_mem[i] = '0; end
        in_mem[0] = 32'd256; in_mem[1] = 32'd512; in_mem[2] = 32'd768;
        w_mem[0] = 32'd1; w_mem[1] = 32'd1; w_mem[2] = 32'd1;
        w_mem[3] = 32'd2; w_mem[4] = 32'd0; w_mem[5] = 32'hFFFF_FFFF;
        b_mem[0] = 32'd2560; b_mem[1] = -32'sd5120;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({done, out_we, in_ra, w_ra, b_ra, out_wa, out_wd} !== '0)
            $display("FAIL reset_outputs got %b/%b ra=%h/%h/%h wa=%h wd=%h, required all 0",
                     done, out_we, in_ra, w_ra, b_ra, out_wa, out_wd);
        else passed++;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        load_basic();
        push_job(3, 2, 1'b0);
        run_and_wait(3, 2, 1'b0, 10, "basic");
        total++;
        if (out_mem[0] !== 32'd16) $display("FAIL basic_out0 got %h, required %h", out_mem[0], 32'd16);
        else passed++;
        total++;
        if (out_mem[1] !== 32'hFFFF_FFEB) $display("FAIL basic_out1 got %h, required %h", out_mem[1], 32'hFFFF_FFEB);
        else passed++;
        end_job("basic");
    endtask

    task automatic test_relu();
        int w0;
        w0 = n_writes;
        push_job(3, 2, 1'b1);
        run_and_wait(3, 2, 1'b1, 10, "relu");
        total++;
        if (out_mem[1] !== 32'd0) $display("FAIL relu_out1 got %h, required 0", out_mem[1]);
        else passed++;
        total++;
        if (n_writes - w0 !== 2) $display("FAIL relu_writes got %0d, required 2", n_writes - w0);
        else passed++;
        end_job("relu");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) begin in_mem[i] = 32'h7FFF_FFFF; w_mem[i] = 32'h7FFF_FFFF; end
        b_mem[0] = '0;
        push_job(4, 1, 1'b0);
        run_and_wait(4, 1, 1'b0, 6, "sat_pos");
        total++;
        if (out_mem[0] !== 32'h7FFF_FFFF) $display("FAIL sat_pos_val got %h, required 7fffffff", out_mem[0]);
        else passed++;
        end_job("sat_pos");
        for (int i = 0; i < 4; i++) w_mem[i] = 32'h8000_0001;
        push_job(4, 1, 1'b0);
        run_and_wait(4, 1, 1'b0, 6, "sat_neg");
        total++;
        if (out_mem[0] !== 32'h8000_0000) $display("FAIL sat_neg_val got %h, required 80000000", out_mem[0]);
        else passed++;
        end_job("sat_neg");
    endtask

    task automatic test_bias_only();
        b_mem[0] = 32'd1280; b_mem[1] = -32'sd1536; b_mem[2] = 32'd1792;
        push_job(0, 3, 1'b0);
        run_and_wait(0, 3, 1'b0, 6, "bias_only");
        total++;
        if ({out_mem[0], out_mem[1], out_mem[2]} !== {32'd5, 32'hFFFF_FFFA, 32'd7})
            $display("FAIL bias_only_vals got %h %h %h, required 5 fffffffa 7", out_mem[0], out_mem[1], out_mem[2]);
        else passed++;
        end_job("bias_only");
    endtask

    task automatic test_zero_out();
        int w0;
        w0 = n_writes;
        run_and_wait(3, 0, 1'b0, 0, "zero_out");
        total++;
        if (n_writes !== w0) $display("FAIL zero_out_writes got %0d, required 0", n_writes - w0);
        else passed++;
        end_job("zero_out");
    endtask

    task automatic test_reset_mid();
        int w0;
        load_basic();
        w0 = n_writes;
        sb.push_back('{addr: 16'd0, data: model(3, 0, 1'b0)});
        N_IN = 3; N_OUT = 2; RELU = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({done, out_we, in_ra, w_ra, b_ra, out_wa, out_wd} !== '0)
            $display("FAIL rst_mid_outputs got %b/%b ra=%h/%h/%h wa=%h wd=%h, required all 0",
                     done, out_we, in_ra, w_ra, b_ra, out_wa, out_wd);
        else passed++;
        en = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        total++;
        if (n_writes - w0 !== 1 || sb.size() !== 0)
            $display("FAIL rst_mid_writes got %0d writes %0d pending, required 1 and 0", n_writes - w0, sb.size());
        else passed++;
    endtask

    task automatic test_abort();
        int w0;
        bit saw_done;
        w0 = n_writes;
        saw_done = 1'b0;
        sb.push_back('{addr: 16'd0, data: model(3, 0, 1'b0)});
        N_IN = 3; N_OUT = 2; RELU = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        repeat (6) begin @(posedge clk); #1; end
        en = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) $display("FAIL abort_done got 1, required 0");
        else passed++;
        total++;
        if (n_writes - w0 !== 1) $display("FAIL abort_writes got %0d, required 1", n_writes - w0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int w0;
        bit dropped;
        logic [31:0] first0, first1;
        push_job(3, 2, 1'b0);
        run_and_wait(3, 2, 1'b0, 10, "hold");
        first0 = out_mem[0]; first1 = out_mem[1];
        w0 = n_writes;
        dropped = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (!done) dropped = 1'b1;
        end
        total++;
        if (dropped !== 1'b0 || n_writes !== w0)
            $display("FAIL hold_done got dropped=%b writes=%0d, required dropped=0 writes=0", dropped, n_writes - w0);
        else passed++;
        end_job("hold");
        out_mem[0] = '0; out_mem[1] = '0;
        push_job(3, 2, 1'b0);
        run_and_wait(3, 2, 1'b0, 10, "rerun");
        total++;
        if (out_mem[0] !== first0 || out_mem[1] !== first1)
            $display("FAIL rerun_same got %h %h, required %h %h", out_mem[0], out_mem[1], first0, first1);
        else passed++;
        end_job("rerun");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            in_mem[i] = '0; w_mem[i] = '0; b_mem[i] = '0; out_mem[i] = '0;
        end
        test_reset();
        test_basic();
        test_relu();
        test_saturate();
        test_bias_only();
        test_zero_out();
        test_reset_mid();
        test_abort();
        load_basic();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
